lfsr_encrypter: RTL and testbench

//  Lab-5 upstream stage: builds the encrypted message that the lab-5 decrypter consumes.

---
 rtl/lfsr_pkg.sv | 33 +++
 rtl/lfsr_encrypter_if.sv | 20 ++
 rtl/lfsr6.sv | 35 +++
 rtl/lfsr_encrypter.sv | 120 ++++++++++++
 tb/tb_lfsr_encrypter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the lab-5 LFSR encrypter/decrypter pair: memory map,
// tap table, FSM states and the single-step LFSR function.
package lfsr_pkg;

  localparam logic [7:0] MSG_BASE   = 8'd0;
  localparam logic [7:0] OUT_BASE   = 8'd64;
  localparam logic [7:0] SEL_ADDR   = 8'd61;
  localparam logic [7:0] PREL_ADDR  = 8'd62;
  localparam logic [7:0] SEED_ADDR  = 8'd63;
  localparam logic [7:0] PREL_MIN   = 8'd7;
  localparam logic [7:0] PREL_MAX   = 8'd12;
  localparam logic [7:0] UNDERSCORE = 8'h5F;
  localparam logic [5:0] LAST_K     = 6'd63;
  localparam logic [2:0] SEL_MAX    = 3'd5;

  localparam logic [5:0] TAPS [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG0,
    ST_CFG1,
    ST_CFG2,
    ST_CFG3,
    ST_ENC,
    ST_DONE
  } state_e;

  // Shift left, feedback bit is the parity of the tapped state bits.
  function automatic logic [5:0] lfsr_next(input logic [5:0] taps, input logic [5:0] state);
    return {state[4:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_encrypter_if.sv
// Data-memory port shared by the encrypter and the dat_mem model.
interface lfsr_encrypter_if;

  logic [7:0] mem_rdata;
  logic [7:0] mem_raddr;
  logic [7:0] mem_waddr;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;

  modport master (
    input  mem_rdata,
    output mem_raddr, mem_waddr, mem_wr_en, mem_wdata
  );

  modport slave (
    output mem_rdata,
    input  mem_raddr, mem_waddr, mem_wr_en, mem_wdata
  );

endinterface

// File: rtl/lfsr6.sv
// 6-bit Fibonacci-style LFSR register with seed load and step enable.
module lfsr6
  import lfsr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] seed,
  input  logic       step,
  input  logic [5:0] taps,
  output logic [5:0] state
);

  logic [5:0] state_q, state_d;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (load) begin
      // An all-zero seed would lock the register up forever.
      state_d = (seed == 6'h00) ? 6'h01 : seed;
    end else if (step) begin
      state_d = lfsr_next(taps, state_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= 6'h01;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_encrypter.sv
// Lab-5 encrypter: reads config and plaintext, writes a 64-byte preamble+message
// stream XORed with a 6-bit LFSR keystream to mem[64..127].
module lfsr_encrypter
  import lfsr_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  output logic                      done,
  lfsr_encrypter_if.master          mem
);

  state_e     state_q, state_d;
  logic       init_q, init_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] prel_q, prel_d;
  logic [5:0] k_q, k_d;

  logic       lfsr_load, lfsr_step;
  logic [5:0] lfsr;
  logic [7:0] k_ext, prel_ext, rd_next, msg_off;

  lfsr6 u_lfsr (
    .clk   (clk),
    .rst   (reset),
    .load  (lfsr_load),
    .seed  (mem.mem_rdata[5:0]),
    .step  (lfsr_step),
    .taps  (TAPS[sel_q]),
    .state (lfsr)
  );

  // Plaintext byte (k+1-prel) is requested one cycle ahead of use; the last
  // cycle re-requests the final consumed byte so no read goes beyond it.
  assign k_ext    = {2'b00, k_q};
  assign prel_ext = {4'h0, prel_q};
  assign rd_next  = (k_q == LAST_K) ? k_ext : k_ext + 8'd1;
  assign msg_off  = (rd_next >= prel_ext) ? rd_next - prel_ext : 8'd0;

  always_comb begin
    state_d       = state_q;
    init_d        = init;
    sel_d         = sel_q;
    prel_d        = prel_q;
    k_d           = k_q;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;
    done          = 1'b0;
    mem.mem_raddr = 8'd0;
    mem.mem_waddr = 8'd0;
    mem.mem_wr_en = 1'b0;
    mem.mem_wdata = 8'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (init_q && !init) state_d = ST_CFG0;
      end
      ST_CFG0: begin
        mem.mem_raddr = SEL_ADDR;
        state_d       = ST_CFG1;
      end
      ST_CFG1: begin
        mem.mem_raddr = PREL_ADDR;
        sel_d         = (mem.mem_rdata[2:0] > SEL_MAX) ? SEL_MAX : mem.mem_rdata[2:0];
        state_d       = ST_CFG2;
      end
      ST_CFG2: begin
        mem.mem_raddr = SEED_ADDR;
        if (mem.mem_rdata < PREL_MIN)      prel_d = PREL_MIN[3:0];
        else if (mem.mem_rdata > PREL_MAX) prel_d = PREL_MAX[3:0];
        else                               prel_d = mem.mem_rdata[3:0];
        state_d = ST_CFG3;
      end
      ST_CFG3: begin
        mem.mem_raddr = MSG_BASE;
        lfsr_load     = 1'b1;
        k_d           = 6'd0;
        state_d       = ST_ENC;
      end
      ST_ENC: begin
        mem.mem_raddr = MSG_BASE + msg_off;
        mem.mem_waddr = OUT_BASE + k_ext;
        mem.mem_wr_en = 1'b1;
        mem.mem_wdata = ((k_ext < prel_ext) ? UNDERSCORE : mem.mem_rdata) ^ {2'b00, lfsr};
        lfsr_step     = 1'b1;
        k_d           = k_q + 6'd1;
        if (k_q == LAST_K) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (init_q && !init) state_d = ST_CFG0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Raising init during a run abandons it; bytes already written stay put.
    if (init && state_q != ST_IDLE && state_q != ST_DONE) begin
      state_d   = ST_IDLE;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      init_q  <= 1'b0;
      sel_q   <= 3'd0;
      prel_q  <= PREL_MIN[3:0];
      k_q     <= 6'd0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      sel_q   <= sel_d;
      prel_q  <= prel_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_lfsr_encrypter.sv
// Self-checking bench for lfsr_encrypter: memory model, keystream reference and
// a tap-searching decrypter model used for round-trip checks.
module tb_lfsr_encrypter;

  localparam int TB_TAPS [6] = '{'h21, 'h2D, 'h30, 'h33, 'h36, 'h39};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init = 1'b0;
  logic done;

  lfsr_encrypter_if bus ();

  lfsr_encrypter dut (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .done  (done),
    .mem   (bus)
  );

  always #5 clk = ~clk;

  // Memory: lower 64 bytes are owned by the stimulus, upper 64 by the DUT.
  logic [7:0] img  [64];
  logic [7:0] outm [64];
  logic       out_clr = 1'b0;
  int         wr_cnt = 0;
  int         bad_rd = 0;

  always @(posedge clk) begin
    if (out_clr) begin
      for (int i = 0; i < 64; i++) outm[i] = 8'hAA;
    end else if (bus.mem_wr_en) begin
      wr_cnt = wr_cnt + 1;
      if (bus.mem_raddr > 8'd56) bad_rd = bad_rd + 1;
      if (bus.mem_waddr[7:6] == 2'b01) outm[bus.mem_waddr[5:0]] = bus.mem_wdata;
    end
    bus.mem_rdata <= (bus.mem_raddr[7:6] == 2'b00) ? img[bus.mem_raddr[5:0]] : 8'h00;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void gen_key(input int taps, input int seed, output logic [7:0] ks [64]);
    int s;
    s = seed;
    for (int k = 0; k < 64; k++) begin
      ks[k] = 8'(s);
      s = ((s << 1) & 63) | ($countones(s & taps) & 1);
    end
  endfunction

  function automatic void expect_out(input int sel, input int prel, input int seed,
                                     input logic [7:0] txt [57], output logic [7:0] e [64]);
    logic [7:0] ks [64];
    int s, p, sd;
    s  = sel & 7;   if (s > 5) s = 5;
    p  = prel & 255; if (p < 7) p = 7; if (p > 12) p = 12;
    sd = seed & 63; if (sd == 0) sd = 1;
    gen_key(TB_TAPS[s], sd, ks);
    for (int k = 0; k < 64; k++) e[k] = ((k < p) ? 8'h5F : txt[k - p]) ^ ks[k];
  endfunction

  // Decrypter model: seed from first byte, try each tap set, accept the one
  // giving a 7..12 underscore preamble followed by upper-case letters.
  function automatic bit decrypt(input logic [7:0] ct [64], output logic [7:0] pt [57], output int plen);
    logic [7:0] ks [64];
    logic [7:0] d  [64];
    int seed, n;
    bit ok;
    plen = 0;
    for (int j = 0; j < 57; j++) pt[j] = 8'h00;
    seed = int'(ct[0] ^ 8'h5F);
    if (seed > 63) return 1'b0;
    for (int t = 0; t < 6; t++) begin
      gen_key(TB_TAPS[t], seed, ks);
      for (int k = 0; k < 64; k++) d[k] = ct[k] ^ ks[k];
      n = 0;
      while (n < 64 && d[n] == 8'h5F) n++;
      ok = (n >= 7 && n <= 12);
      for (int k = n; k < 64; k++) if (d[k] < 8'h41 || d[k] > 8'h5A) ok = 1'b0;
      if (ok) begin
        for (int j = 0; j < 64 - n; j++) pt[j] = d[n + j];
        plen = n;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic clear_out();
    @(negedge clk) out_clr = 1'b1;
    @(negedge clk) out_clr = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!done && n < 300);
  endtask

  task automatic launch(output int n);
    @(negedge clk) init = 1'b1;
    @(negedge clk) init = 1'b0;
    wait_done(n);
  endtask

  task automatic load_img(input int sel, input int prel, input int seed, input logic [7:0] txt [57]);
    for (int i = 0; i < 57; i++) img[i] = txt[i];
    for (int i = 57; i < 61; i++) img[i] = 8'($urandom);
    img[61] = 8'(sel);
    img[62] = 8'(prel);
    img[63] = 8'(seed);
  endtask

  task automatic run_case(input string tag, input int sel, input int prel, input int seed,
                          input logic [7:0] txt [57], output logic [7:0] got [64]);
    logic [7:0] e [64];
    int n, w0, b0, mism;
    load_img(sel, prel, seed, txt);
    clear_out();
    w0 = wr_cnt;
    b0 = bad_rd;
    launch(n);
    check({tag, ":latency"}, n, 69);
    check({tag, ":writes"}, wr_cnt - w0, 64);
    check({tag, ":read_range"}, bad_rd - b0, 0);
    expect_out(sel, prel, seed, txt, e);
    mism = 0;
    for (int k = 0; k < 64; k++) if (outm[k] !== e[k]) mism++;
    check({tag, ":bytes"}, mism, 0);
    got = outm;
  endtask

  function automatic int diff_cnt(input logic [7:0] a [64], input logic [7:0] b [64]);
    int m;
    m = 0;
    for (int k = 0; k < 64; k++) if (a[k] !== b[k]) m++;
    return m;
  endfunction

  logic [7:0] txt  [57];
  logic [7:0] got1 [64];
  logic [7:0] got2 [64];
  logic [7:0] ks   [64];
  logic [7:0] e    [64];
  logic [7:0] pt   [57];

  initial begin
    int n, w0, plen, mism, cnt, sel, prel, seed;
    bit ok;

    for (int i = 0; i < 64; i++) img[i] = 8'h00;
    for (int i = 0; i < 57; i++) txt[i] = 8'($urandom_range(65, 90));
    txt[0] = 8'h41;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst:done", done, 0);
    check("rst:wr_en", bus.mem_wr_en, 0);
    check("rst:raddr", bus.mem_raddr, 0);
    check("rst:waddr", bus.mem_waddr, 0);
    check("rst:wdata", bus.mem_wdata, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle:done", done, 0);

    // Test 1: sel 0, prel 7, seed 1, first char 'A'
    run_case("t1", 0, 7, 1, txt, got1);
    check("t1:mem64", got1[0], 8'h5E);
    check("t1:mem65", got1[1], 8'h5C);
    check("t1:mem71", got1[7], 8'h7C);
    check("t1:done", done, 1);

    // init held low after completion: nothing restarts
    w0 = wr_cnt;
    repeat (20) @(negedge clk);
    check("hold:writes", wr_cnt - w0, 0);
    check("hold:done", done, 1);

    // Test 2: zero seed behaves as seed 1
    run_case("t2", 0, 7, 0, txt, got2);
    check("t2:same_as_t1", diff_cnt(got1, got2), 0);

    // Test 3: preamble clamping and select saturation
    run_case("t3_prel3", 0, 3, 1, txt, got2);
    check("t3_prel3:same_as_t1", diff_cnt(got1, got2), 0);
    run_case("t3_prelFF", 0, 8'hFF, 1, txt, got2);
    gen_key('h21, 1, ks);
    cnt = 0;
    for (int k = 0; k < 12; k++) if ((got2[k] ^ ks[k]) == 8'h5F) cnt++;
    check("t3_prelFF:underscores", cnt, 12);
    check("t3_prelFF:first_char", got2[12] ^ ks[12], 8'h41);
    seed = $urandom_range(1, 63);
    run_case("t3_sel5", 5, 9, seed, txt, got1);
    run_case("t3_sel7", 7, 9, seed, txt, got2);
    check("t3:sel7_eq_sel5", diff_cnt(got1, got2), 0);

    // Test 4: abort at k=30, then a full rerun
    load_img(2, 8, 8'h2A, txt);
    clear_out();
    @(negedge clk) init = 1'b1;
    @(negedge clk) init = 1'b0;
    n = 0;
    while (!(bus.mem_wr_en && bus.mem_waddr == 8'd94) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t4:reach_k30", n < 200, 1);
    init = 1'b1;
    @(negedge clk);
    check("t4:abort_wr_en", bus.mem_wr_en, 0);
    check("t4:abort_done", done, 0);
    expect_out(2, 8, 8'h2A, txt, e);
    check("t4:k30_written", outm[30], e[30]);
    check("t4:k31_untouched", outm[31], 8'hAA);
    w0 = wr_cnt;
    init = 1'b0;
    wait_done(n);
    check("t4:rerun_latency", n, 69);
    check("t4:rerun_writes", wr_cnt - w0, 64);
    check("t4:rerun_bytes", diff_cnt(outm, e), 0);

    // Test 5: asynchronous reset in the middle of ENC
    load_img(3, 10, 8'h15, txt);
    @(negedge clk) init = 1'b1;
    @(negedge clk) init = 1'b0;
    n = 0;
    while (!(bus.mem_wr_en && bus.mem_waddr == 8'd84) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5:reach_k20", n < 200, 1);
    #2 reset = 1'b1;
    #1;
    check("t5:wr_en", bus.mem_wr_en, 0);
    check("t5:waddr", bus.mem_waddr, 0);
    check("t5:wdata", bus.mem_wdata, 0);
    check("t5:raddr", bus.mem_raddr, 0);
    check("t5:done", done, 0);
    @(negedge clk) reset = 1'b0;
    w0 = wr_cnt;
    repeat (10) @(negedge clk);
    check("t5:idle_writes", wr_cnt - w0, 0);
    check("t5:idle_done", done, 0);
    run_case("t5_rerun", 3, 10, 8'h15, txt, got1);

    // Test 6: round trip through the decrypter model
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 57; i++) txt[i] = 8'($urandom_range(65, 90));
      sel  = s;
      prel = $urandom_range(7, 12);
      seed = $urandom_range(0, 255);
      run_case($sformatf("t6_sel%0d", s), sel, prel, seed, txt, got1);
      ok = decrypt(got1, pt, plen);
      check($sformatf("t6_sel%0d:decrypt_ok", s), ok, 1);
      check($sformatf("t6_sel%0d:plen", s), plen, prel);
      mism = 0;
      for (int j = 0; j < 64 - prel; j++) if (pt[j] !== txt[j]) mism++;
      check($sformatf("t6_sel%0d:text", s), mism, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
